// File: rtl/timer_cascada_pkg.sv
// Shared constants, direction encoding and BCD helper for the cascaded timer.
package timer_cascada_pkg;

  localparam int unsigned DefModulus = 60;
  localparam int unsigned DefWidth   = 6;

  typedef enum logic {
    DirSus = 1'b0,
    DirJos = 1'b1
  } dir_e;

  // Two BCD digits for a value below 100: tens in the upper nibble.
  function automatic logic [7:0] bin_to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/timer_cascada_treapta_mod.sv
// Single modulo-MODULUS counter stage (treapta_mod) with up/down stepping and clamped preset load.
module treapta_mod
  import timer_cascada_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MODULUS = DefModulus
) (
  input  logic             clk_out_led,
  input  logic             reset,
  input  logic             step_i,
  input  dir_e             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] val_o,
  output logic             at_max_o,
  output logic             at_zero_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] val_q, val_d;

  assign val_o     = val_q;
  assign at_max_o  = (val_q == MaxVal);
  assign at_zero_o = (val_q == '0);

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (step_i) begin
      if (dir_i == DirJos) begin
        val_d = at_zero_o ? MaxVal : val_q - WIDTH'(1);
      end else begin
        val_d = at_max_o ? '0 : val_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_out_led or posedge reset) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/timer_cascada.sv
// Cascaded up/down modulo counter with preset load, wrap/zero pulse and sticky expired flag.
// Optional BCD output under TIMER_CASCADA_BCD_EN.
module timer_cascada
  import timer_cascada_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MODULUS = DefModulus
) (
  input  logic                    clk_out_led,
  input  logic                    reset,
  input  logic                    pauza,
  input  logic                    jos,
  input  logic                    incarca,
  input  logic [STAGES*WIDTH-1:0] valoare_inc,
  output logic [STAGES*WIDTH-1:0] valoarea_bin,
`ifdef TIMER_CASCADA_BCD_EN
  output logic [STAGES*8-1:0]     valoarea_bcd,
`endif
  output logic                    carry_out,
  output logic                    expirat
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_param_chk
    $error("timer_cascada: MODULUS must lie in 2..2^WIDTH");
  end

  dir_e             dir;
  logic [STAGES-1:0] step, at_max, at_zero;
  logic [WIDTH-1:0]  stage_val [STAGES];
  logic              all_max, all_zero, hi_zero, is_one;
  logic              carry_q, carry_d, expirat_q, expirat_d;

  assign dir = dir_e'(jos);

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    treapta_mod #(
      .WIDTH  (WIDTH),
      .MODULUS(MODULUS)
    ) u_treapta (
      .clk_out_led(clk_out_led),
      .reset      (reset),
      .step_i     (step[i]),
      .dir_i      (dir),
      .load_i     (incarca),
      .load_val_i (valoare_inc[i*WIDTH +: WIDTH]),
      .val_o      (stage_val[i]),
      .at_max_o   (at_max[i]),
      .at_zero_o  (at_zero[i])
    );
    assign valoarea_bin[i*WIDTH +: WIDTH] = stage_val[i];
  end

  assign all_max  = &at_max;
  assign all_zero = &at_zero;

  always_comb begin
    hi_zero = 1'b1;
    for (int i = 1; i < STAGES; i++) begin
      hi_zero = hi_zero & at_zero[i];
    end
    is_one = hi_zero && (stage_val[0] == WIDTH'(1));
  end

  // Ripple enable: a stage steps only when every lower stage is about to wrap.
  // Down mode freezes the whole chain once it sits at zero.
  always_comb begin
    step    = '0;
    step[0] = !incarca && !pauza && !((dir == DirJos) && all_zero);
    for (int i = 1; i < STAGES; i++) begin
      step[i] = step[i-1] && ((dir == DirJos) ? at_zero[i-1] : at_max[i-1]);
    end
  end

  always_comb begin
    carry_d   = 1'b0;
    expirat_d = expirat_q;
    if (incarca) begin
      expirat_d = 1'b0;
    end else if (!pauza) begin
      if (dir == DirSus) begin
        carry_d   = all_max;
        expirat_d = 1'b0;
      end else if (all_zero) begin
        expirat_d = 1'b1;
      end else if (is_one) begin
        carry_d   = 1'b1;
        expirat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_out_led or posedge reset) begin
    if (reset) begin
      carry_q   <= 1'b0;
      expirat_q <= 1'b0;
    end else begin
      carry_q   <= carry_d;
      expirat_q <= expirat_d;
    end
  end

  assign carry_out = carry_q;
  assign expirat   = expirat_q;

`ifdef TIMER_CASCADA_BCD_EN
  if (MODULUS > 100) begin : g_bcd_chk
    $error("timer_cascada: BCD output requires MODULUS <= 100");
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_bcd
    assign valoarea_bcd[i*8 +: 8] = bin_to_bcd(int unsigned'(stage_val[i]));
  end
`endif

endmodule

// File: tb/tb_timer_cascada.sv
// Directed self-checking bench for timer_cascada with STAGES=2, MODULUS=60.
module tb_timer_cascada;

  localparam int unsigned Stages = 2;
  localparam int unsigned Width  = 6;

  logic                    clk_out_led;
  logic                    reset;
  logic                    pauza;
  logic                    jos;
  logic                    incarca;
  logic [Stages*Width-1:0] valoare_inc;
  logic [Stages*Width-1:0] valoarea_bin;
  logic                    carry_out;
  logic                    expirat;
`ifdef TIMER_CASCADA_BCD_EN
  logic [Stages*8-1:0]     valoarea_bcd;
`endif

  int n_vec;
  int n_err;

  timer_cascada #(
    .STAGES (Stages),
    .WIDTH  (Width),
    .MODULUS(60)
  ) dut (
    .clk_out_led (clk_out_led),
    .reset       (reset),
    .pauza       (pauza),
    .jos         (jos),
    .incarca     (incarca),
    .valoare_inc (valoare_inc),
    .valoarea_bin(valoarea_bin),
`ifdef TIMER_CASCADA_BCD_EN
    .valoarea_bcd(valoarea_bcd),
`endif
    .carry_out   (carry_out),
    .expirat     (expirat)
  );

  initial clk_out_led = 1'b0;
  always #5 clk_out_led = ~clk_out_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_out_led);
    #1;
  endtask

  function automatic logic [31:0] pk(input int unsigned s1, input int unsigned s0);
    logic [5:0] a;
    logic [5:0] b;
    a = 6'(s1);
    b = 6'(s0);
    return {20'd0, a, b};
  endfunction

  task automatic load(input int unsigned s1, input int unsigned s0);
    logic [5:0] a;
    logic [5:0] b;
    a = 6'(s1);
    b = 6'(s0);
    valoare_inc = {a, b};
    incarca     = 1'b1;
    tick();
    incarca     = 1'b0;
  endtask

  int carries;
  int last_carry;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pauza = 1'b0;
    jos = 1'b0;
    incarca = 1'b0;
    valoare_inc = '0;
    #12;
    chk("reset_val", 32'(valoarea_bin), 0);
    chk("reset_carry", 32'(carry_out), 0);
    chk("reset_exp", 32'(expirat), 0);
    reset = 1'b0;

    // 1: full up-count cycle of 3600 edges
    carries = 0;
    last_carry = 0;
    for (int e = 1; e <= 3600; e++) begin
      tick();
      if (carry_out) begin
        carries++;
        last_carry = e;
      end
      if (e == 60) begin
        chk("up60_val", 32'(valoarea_bin), pk(1, 0));
        chk("up60_nocarry", 32'(carries), 0);
      end
    end
    chk("up3600_val", 32'(valoarea_bin), 0);
    chk("up3600_carries", 32'(carries), 1);
    chk("up3600_at", 32'(last_carry), 3600);
    tick();
    chk("up3601_val", 32'(valoarea_bin), pk(0, 1));
    chk("up3601_carry", 32'(carry_out), 0);

    // 2: wrap from {59,59}
    load(59, 59);
    chk("ld5959", 32'(valoarea_bin), pk(59, 59));
    tick();
    chk("wrap_val", 32'(valoarea_bin), 0);
    chk("wrap_carry", 32'(carry_out), 1);
    tick();
    chk("wrap1_val", 32'(valoarea_bin), pk(0, 1));
    chk("wrap1_carry", 32'(carry_out), 0);

    // 3: count down from 60 to zero, then hold
    load(1, 0);
    jos = 1'b1;
    carries = 0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (carry_out) carries++;
      if (e == 1) chk("dn1_val", 32'(valoarea_bin), pk(0, 59));
    end
    chk("dn60_val", 32'(valoarea_bin), 0);
    chk("dn60_carry", 32'(carry_out), 1);
    chk("dn60_carries", 32'(carries), 1);
    chk("dn60_exp", 32'(expirat), 1);
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("dnhold_val", 32'(valoarea_bin), 0);
      chk("dnhold_carry", 32'(carry_out), 0);
      chk("dnhold_exp", 32'(expirat), 1);
    end

    // 4: pause, then load while paused clears expirat
    jos = 1'b0;
    load(3, 16);
    tick();
    chk("pre_pause", 32'(valoarea_bin), pk(3, 17));
    pauza = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("pause_val", 32'(valoarea_bin), pk(3, 17));
      chk("pause_carry", 32'(carry_out), 0);
    end
    pauza = 1'b0;
    jos = 1'b1;
    load(0, 0);
    chk("ld0_exp", 32'(expirat), 0);
    tick();
    chk("zero_exp", 32'(expirat), 1);
    chk("zero_nocarry", 32'(carry_out), 0);
    chk("zero_val", 32'(valoarea_bin), 0);
    pauza = 1'b1;
    tick();
    chk("pause_exp_hold", 32'(expirat), 1);
    load(2, 5);
    chk("pld_val", 32'(valoarea_bin), pk(2, 5));
    chk("pld_exp", 32'(expirat), 0);
    tick();
    chk("pld_hold", 32'(valoarea_bin), pk(2, 5));
    pauza = 1'b0;
    tick();
    chk("dn_after_pause", 32'(valoarea_bin), pk(2, 4));
    jos = 1'b0;
    tick();
    chk("dir_change_val", 32'(valoarea_bin), pk(2, 5));
    chk("dir_change_carry", 32'(carry_out), 0);

    // 5: clamp on load
    load(60, 63);
    chk("clamp", 32'(valoarea_bin), pk(59, 59));

    // 6: asynchronous reset between edges, and over a same-edge load
    load(12, 33);
    tick();
    chk("pre_rst", 32'(valoarea_bin), pk(12, 34));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_val", 32'(valoarea_bin), 0);
    chk("rst_carry", 32'(carry_out), 0);
    chk("rst_exp", 32'(expirat), 0);
    valoare_inc = pk(7, 7);
    incarca = 1'b1;
    tick();
    chk("rst_over_load", 32'(valoarea_bin), 0);
    incarca = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst1", 32'(valoarea_bin), pk(0, 1));
    tick();
    chk("post_rst2", 32'(valoarea_bin), pk(0, 2));

`ifdef TIMER_CASCADA_BCD_EN
    load(47, 9);
    chk("bcd", 32'(valoarea_bcd), 32'h0000_4709);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
